// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// master: the block that drives commands; slave: the timer itself.
interface countdown_timer_if #(
   parameter int unsigned WIDTH = 4
) ();
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] counter_out;
   logic             busy;
   logic             done;

   modport master (
      output enable, load, load_value, start, abort,
      input  counter_out, busy, done
   );

   modport slave (
      input  enable, load, load_value, start, abort,
      output counter_out, busy, done
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with an IDLE/RUN FSM and a registered one-cycle
// done pulse on terminal count. All outputs come straight from flops.
// Optional auto-reload is compiled in with `define COUNTDOWN_TIMER_AUTORELOAD_EN:
// the counter then restarts from the last loaded value instead of stopping,
// and only abort (or reset) leaves RUN.
module countdown_timer #(
   parameter int unsigned WIDTH = 4
) (
   input logic                clk,
   input logic                reset,
   countdown_timer_if.slave   tmr_io
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             done_q, done_d;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   // State, count and done pulse registers; synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
   // Reload value captured on every accepted load.
   always_ff @(posedge clk) begin
      if (reset) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end
`endif

   // Next-state logic: load beats start in IDLE, abort beats enable in RUN.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_d = reload_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (tmr_io.load) begin
               count_d = tmr_io.load_value;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
               reload_d = tmr_io.load_value;
`endif
            end else if (tmr_io.start) begin
               // Starting from zero is an immediate terminal count.
               if (count_q != '0) begin
                  state_d = StRun;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (tmr_io.abort) begin
               state_d = StIdle;
            end else if (tmr_io.enable) begin
               if (count_q > WIDTH'(1)) begin
                  count_d = count_q - WIDTH'(1);
               end else if (count_q == WIDTH'(1)) begin
                  done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                  if (reload_q != '0) begin
                     count_d = reload_q;
                  end else begin
                     count_d = '0;
                     state_d = StIdle;
                  end
`else
                  count_d = '0;
                  state_d = StIdle;
`endif
               end else begin
                  // Zero in RUN is unreachable; leave without wrapping.
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are direct register views.
   always_comb begin
      tmr_io.counter_out = count_q;
      tmr_io.busy        = (state_q == StRun);
      tmr_io.done        = done_q;
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed sequences with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_countdown_timer;
   localparam int unsigned W = 4;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   bit   cmp_en;

   // Behavioural model state
   int m_cnt;
   int m_rel;
   bit m_run;
   bit m_done;

   countdown_timer_if #(.WIDTH(W)) bus ();

   countdown_timer #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .tmr_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      if (reset) begin
         m_cnt  = 0;
         m_rel  = 0;
         m_run  = 0;
         m_done = 0;
      end else begin
         m_done = 0;
         if (!m_run) begin
            if (bus.load) begin
               m_cnt = int'(bus.load_value);
               m_rel = int'(bus.load_value);
            end else if (bus.start) begin
               if (m_cnt == 0) m_done = 1;
               else m_run = 1;
            end
         end else if (bus.abort) begin
            m_run = 0;
         end else if (bus.enable) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_done = 1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
               if (m_rel != 0) m_cnt = m_rel;
               else m_run = 0;
`else
               m_run = 0;
`endif
            end
         end
      end
   endtask

   // One clock: drive inputs, let the edge happen, update model, settle.
   task automatic cyc(input bit rst, input bit en, input bit ld, input bit st, input bit ab,
                      input int lv);
      reset          = rst;
      bus.enable     = en;
      bus.load       = ld;
      bus.start      = st;
      bus.abort      = ab;
      bus.load_value = W'(lv);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic lit(input string name, input int cnt, input bit busy, input bit done);
      chk({name, ".cnt"}, int'(bus.counter_out), cnt);
      chk({name, ".busy"}, int'(bus.busy), int'(busy));
      chk({name, ".done"}, int'(bus.done), int'(done));
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mdl.cnt", int'(bus.counter_out), m_cnt);
         chk("mdl.busy", int'(bus.busy), int'(m_run));
         chk("mdl.done", int'(bus.done), int'(m_done));
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      cmp_en   = 0;
      cyc(1, 0, 0, 0, 0, 0);
      cmp_en = 1;
      lit("reset", 0, 0, 0);

`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
      // load 5, start, enable continuous
      cyc(0, 0, 1, 0, 0, 5);  lit("r28.load", 5, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);  lit("r28.start", 5, 1, 0);
      for (int i = 4; i >= 1; i--) begin
         cyc(0, 1, 0, 0, 0, 0); lit("r28.dec", i, 1, 0);
      end
      cyc(0, 1, 0, 0, 0, 0);  lit("r28.term", 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 0);  lit("r28.after", 0, 0, 0);

      // enable toggled 1,0,1,0,1
      cyc(0, 0, 1, 0, 0, 3);
      cyc(0, 0, 0, 1, 0, 0);  lit("r29.start", 3, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);  lit("r29.e1", 2, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);  lit("r29.e0", 2, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);  lit("r29.e1b", 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0);  lit("r29.e0b", 1, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);  lit("r29.term", 0, 0, 1);

      // abort beats enable, then resume
      cyc(0, 0, 1, 0, 0, 9);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);  lit("r30.dec2", 7, 1, 0);
      cyc(0, 1, 0, 0, 1, 0);  lit("r30.abort", 7, 0, 0);
      cyc(0, 1, 0, 0, 1, 0);  lit("r30.idleab", 7, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);  lit("r30.resume", 7, 1, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0);
      lit("r30.one", 1, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);  lit("r30.term", 0, 0, 1);

      // start from zero, then load during RUN is ignored
      cyc(0, 0, 1, 0, 0, 0);  lit("r31.load0", 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);  lit("r31.start0", 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);  lit("r31.pulse", 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 4);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 0, 9);  lit("r31.ldrun", 4, 1, 0);

      // reset mid-countdown
      cyc(1, 1, 0, 0, 0, 0);  lit("r32.reset", 0, 0, 0);
`else
      // auto-reload: 2,1,2,1,... with done each wrap, abort stops
      cyc(0, 0, 1, 0, 0, 2);
      cyc(0, 0, 0, 1, 0, 0);  lit("r33.start", 2, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);  lit("r33.d1", 1, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);  lit("r33.rl1", 2, 1, 1);
      cyc(0, 1, 0, 0, 0, 0);  lit("r33.d2", 1, 1, 0);
      cyc(0, 1, 0, 0, 0, 0);  lit("r33.rl2", 2, 1, 1);
      cyc(0, 1, 0, 0, 1, 0);  lit("r33.abort", 2, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);  lit("r33.reset", 0, 0, 0);
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 11) == 0), int'($urandom_range(0, (1 << W) - 1)));
      end

      @(negedge clk);
      cmp_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
